// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory read port plus the decode-facing delivery port.
// Decode handshake: instr/instr_pc/pc_plus2 are meaningful while instr_valid=1; stall=1 holds them unchanged into the next cycle.
interface fetch_if;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        halted;
    logic        misalign;
    logic [15:0] fetch_count;
    logic        state_dbg;

    modport master (
        output mem_addr, mem_en, instr, instr_pc, pc_plus2, instr_valid,
               halted, misalign, fetch_count, state_dbg,
        input  mem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_en, instr, instr_pc, pc_plus2, instr_valid,
               halted, misalign, fetch_count, state_dbg,
        output mem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, delivers one registered instruction per cycle,
// handles stall, redirect and halt-word detection.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'h0000
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  bus
);
    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] instr_q, instr_nxt;
    logic [15:0] ipc_q, ipc_nxt;
    logic        valid_q, valid_nxt;
    logic        mis_q, mis_nxt;
    logic [15:0] cnt_q, cnt_nxt;
    logic [15:0] cnt_inc;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_RUN;
            pc      <= RESET_PC;
            instr_q <= 16'h0000;
            ipc_q   <= 16'h0000;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr_q <= instr_nxt;
            ipc_q   <= ipc_nxt;
            valid_q <= valid_nxt;
            mis_q   <= mis_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr_q;
        ipc_nxt   = ipc_q;
        valid_nxt = valid_q;
        mis_nxt   = mis_q;
        cnt_nxt   = cnt_q;
        case (state)
            S_RUN: begin
                // Redirect outranks stall and also masks a halt word on the bus.
                if (bus.redirect) begin
                    pc_nxt    = {bus.redirect_pc[15:1], 1'b0};
                    valid_nxt = 1'b0;
                    mis_nxt   = mis_q | bus.redirect_pc[0];
                end else if (!bus.stall) begin
                    instr_nxt = bus.mem_rdata;
                    ipc_nxt   = pc;
                    valid_nxt = 1'b1;
                    cnt_nxt   = cnt_inc;
                    if (bus.mem_rdata == HALT_WORD) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt = pc + 16'd2;
                    end
                end
            end
            S_HALT: begin
                if (!bus.stall) begin
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    assign bus.mem_addr    = pc;
    assign bus.mem_en      = (state == S_RUN) && !bus.stall && !bus.redirect && rst;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.pc_plus2    = ipc_q + 16'd2;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = (state == S_HALT);
    assign bus.misalign    = mis_q;
    assign bus.fetch_count = cnt_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal checks from the plan plus randomized stimulus
// compared every cycle against a behavioural fetch model.
module tb_fetch_unit;
    logic clk;
    logic rst;
    fetch_if fif();

    logic [15:0] mem [0:65535];

    int checks;
    int errors;
    bit cmp_en;

    // behavioural model state
    logic [15:0] m_pc, m_instr, m_ipc, m_cnt;
    bit          m_valid, m_halted, m_mis;

    fetch_unit dut (.clk(clk), .rst(rst), .bus(fif.master));

    assign fif.mem_rdata = mem[fif.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [15:0] w;
        if (!rst) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_cnt = 16'h0000;
            m_valid = 0; m_halted = 0; m_mis = 0;
        end else if (!m_halted) begin
            if (fif.redirect) begin
                m_pc = fif.redirect_pc & 16'hFFFE;
                m_valid = 0;
                if (fif.redirect_pc[0]) m_mis = 1;
            end else if (!fif.stall) begin
                w = mem[m_pc];
                m_instr = w;
                m_ipc = m_pc;
                m_valid = 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (w == 16'h0000) m_halted = 1;
                else m_pc = m_pc + 16'd2;
            end
        end else if (!fif.stall) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_addr", fif.mem_addr, m_pc);
            chk("mem_en", {15'd0, fif.mem_en},
                {15'd0, (!m_halted && !fif.stall && !fif.redirect && rst)});
            chk("instr", fif.instr, m_instr);
            chk("instr_pc", fif.instr_pc, m_ipc);
            chk("pc_plus2", fif.pc_plus2, 16'(m_ipc + 17'd2));
            chk("instr_valid", {15'd0, fif.instr_valid}, {15'd0, m_valid});
            chk("halted", {15'd0, fif.halted}, {15'd0, m_halted});
            chk("state_dbg", {15'd0, fif.state_dbg}, {15'd0, m_halted});
            chk("misalign", {15'd0, fif.misalign}, {15'd0, m_mis});
            chk("fetch_count", fif.fetch_count, m_cnt);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [15:0] rp);
        fif.stall = s;
        fif.redirect = r;
        fif.redirect_pc = rp;
    endtask

    initial begin
        int halt_run;
        checks = 0; errors = 0; cmp_en = 0;
        rst = 1'b0;
        drive(0, 0, 16'h0000);
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom_range(1, 65535));
        mem[0] = 16'h1111; mem[2] = 16'h2222; mem[4] = 16'h3333; mem[6] = 16'h0000;
        mem[16'h0040] = 16'hABCD; mem[16'h0042] = 16'h4242;
        mem[16'hFFFE] = 16'h5555; mem[16'h0060] = 16'h0000;
        @(negedge clk); #1;
        cyc(2);
        cmp_en = 1;

        // reset state and basic sequential fetch
        chk("rst_valid", {15'd0, fif.instr_valid}, 16'd0);
        chk("rst_count", fif.fetch_count, 16'd0);
        chk("rst_addr", fif.mem_addr, 16'h0000);
        rst = 1'b1;
        #1 chk("en_after_rst", {15'd0, fif.mem_en}, 16'd1);
        cyc();
        chk("seq0_instr", fif.instr, 16'h1111);
        chk("seq0_pc", fif.instr_pc, 16'h0000);
        chk("seq0_addr", fif.mem_addr, 16'h0002);
        cyc();
        chk("seq1_instr", fif.instr, 16'h2222);

        // stall holds everything
        drive(1, 0, 16'h0000);
        cyc(3);
        #1;
        chk("stall_instr", fif.instr, 16'h2222);
        chk("stall_pc", fif.instr_pc, 16'h0002);
        chk("stall_addr", fif.mem_addr, 16'h0004);
        chk("stall_en", {15'd0, fif.mem_en}, 16'd0);
        chk("stall_count", fif.fetch_count, 16'd2);
        drive(0, 0, 16'h0000);
        cyc();
        chk("post_stall_instr", fif.instr, 16'h3333);
        chk("post_stall_pc", fif.instr_pc, 16'h0004);
        cyc();
        chk("halt_instr", fif.instr, 16'h0000);
        chk("halt_pc", fif.instr_pc, 16'h0006);
        chk("halt_flag", {15'd0, fif.halted}, 16'd1);
        chk("halt_count", fif.fetch_count, 16'd4);
        chk("halt_plus2", fif.pc_plus2, 16'h0008);
        cyc();
        chk("halt_novalid", {15'd0, fif.instr_valid}, 16'd0);
        chk("halt_addr", fif.mem_addr, 16'h0006);

        // redirect ignored in HALT, then reset leaves it
        drive(0, 1, 16'h0010);
        cyc();
        chk("halt_redir_ign", fif.mem_addr, 16'h0006);
        chk("halt_redir_flag", {15'd0, fif.halted}, 16'd1);
        drive(0, 0, 16'h0000);
        rst = 1'b0;
        cyc();
        chk("rst2_halted", {15'd0, fif.halted}, 16'd0);
        chk("rst2_instr", fif.instr, 16'h0000);
        chk("rst2_count", fif.fetch_count, 16'd0);
        rst = 1'b1;
        cyc(3);
        chk("pre_redir_addr", fif.mem_addr, 16'h0006);

        // redirect over a halt word
        drive(0, 1, 16'h0040);
        cyc();
        chk("redir_valid", {15'd0, fif.instr_valid}, 16'd0);
        chk("redir_halted", {15'd0, fif.halted}, 16'd0);
        chk("redir_addr", fif.mem_addr, 16'h0040);
        drive(0, 0, 16'h0000);
        cyc();
        chk("redir_instr", fif.instr, 16'hABCD);
        chk("redir_ipc", fif.instr_pc, 16'h0040);

        // misaligned redirect, then PC wrap
        drive(0, 1, 16'h0043);
        cyc();
        chk("mis_addr", fif.mem_addr, 16'h0042);
        chk("mis_flag", {15'd0, fif.misalign}, 16'd1);
        drive(0, 1, 16'hFFFE);
        cyc();
        drive(0, 0, 16'h0000);
        cyc();
        chk("wrap_ipc", fif.instr_pc, 16'hFFFE);
        chk("wrap_plus2", fif.pc_plus2, 16'h0000);
        chk("wrap_addr", fif.mem_addr, 16'h0000);
        chk("mis_sticky", {15'd0, fif.misalign}, 16'd1);

        // stall in HALT keeps valid, release drops it
        drive(0, 1, 16'h0060);
        cyc();
        drive(0, 0, 16'h0000);
        cyc();
        chk("h2_flag", {15'd0, fif.halted}, 16'd1);
        drive(1, 0, 16'h0000);
        cyc(2);
        chk("h2_stall_valid", {15'd0, fif.instr_valid}, 16'd1);
        drive(0, 0, 16'h0000);
        cyc();
        chk("h2_release_valid", {15'd0, fif.instr_valid}, 16'd0);
        rst = 1'b0;
        cyc();
        chk("rst3_mis", {15'd0, fif.misalign}, 16'd0);
        rst = 1'b1;

        // randomized phase
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 24) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
        halt_run = 0;
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), tgt);
            halt_run = fif.halted ? halt_run + 1 : 0;
            rst = !(($urandom_range(0, 99) == 0) || halt_run > 4);
            cyc();
        end
        rst = 1'b1;
        drive(0, 0, 16'h0000);
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the 16-bit single-issue core; drives the instruction memory (memory2c, read-only use) and delivers one instruction per cycle to decode.
- Owns the PC, sequential +2 increment, stall hold, branch/jump redirect, and halt detection (instruction word 16'h0000).
- Registered fetch stage: the address is presented in cycle N, and the instruction, its PC and instr_valid are visible at decode in cycle N+1.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_WORD, 16'h0000, instruction encoding that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising clk edge resets the block).
- mem_addr  out  16  instruction memory address; always equals the internal pc.
- mem_en  out  1  memory read enable.
- mem_rdata  in  16  memory read data; combinational, valid in the same cycle as mem_addr/mem_en.
- stall  in  1  decode back-pressure; hold all fetch state.
- redirect  in  1  load redirect_pc into the PC and squash the in-flight output.
- redirect_pc  in  16  redirect target.
- instr  out  16  fetched instruction (registered).
- instr_pc  out  16  address the instruction was fetched from.
- pc_plus2  out  16  instr_pc + 2, modulo 2^16.
- instr_valid  out  1  instr/instr_pc/pc_plus2 are meaningful.
- halted  out  1  high while in state HALT.
- misalign  out  1  sticky flag: a redirect with redirect_pc[0]==1 was taken.
- fetch_count  out  16  number of instructions delivered with instr_valid; saturates at 16'hFFFF.

Behaviour:
- Reset (rst==0 at a clk edge):
  - pc=RESET_PC; instr=0; instr_pc=0; instr_valid=0; halted=0; misalign=0; fetch_count=0.
  - State=RUN; reset has priority over every other input.
- mem_addr = pc at all times.
- mem_en = 1 only when: state==RUN, stall==0, redirect==0, and rst==1.
- States RUN and HALT. Per edge in RUN, first matching rule applies:
  1. redirect==1:
     - pc = {redirect_pc[15:1],1'b0}; instr_valid=0.
     - misalign |= redirect_pc[0].
     - Takes priority over stall and over halt detection on mem_rdata.
  2. stall==1: pc, instr, instr_pc, instr_valid and fetch_count all hold.
  3. mem_rdata==HALT_WORD:
     - instr=HALT_WORD; instr_pc=pc; instr_valid=1; pc holds; state goes to HALT.
  4. Otherwise:
     - instr=mem_rdata; instr_pc=pc; instr_valid=1; pc=pc+2 (wraps 16'hFFFE to 16'h0000).
- fetch_count increments on every edge that loads instr_valid=1 (rules 3 and 4); it does not change on a stalled hold; saturates, never wraps.
- HALT state:
  - halted=1; mem_en=0; pc frozen.
  - redirect is ignored.
  - While stall==1, instr_valid holds. On the first edge with stall==0, instr_valid goes to 0 and stays 0.
  - Only reset leaves HALT.
- pc_plus2 = instr_pc+2, combinational from the registered instr_pc.
- Reset asserted mid-stall or in HALT: full reset values next cycle, with fetch from RESET_PC in the following cycle.
- redirect and stall together: redirect wins; the output is squashed.

Test Plan:
- Memory preloaded with 16'h1111, 16'h2222, 16'h3333, 16'h0000 at addresses 0, 2, 4, 6; release reset → mem_addr steps 0, 2, 4, 6. instr/instr_pc pairs are 1111/0, 2222/2, 3333/4, 0000/6 on consecutive cycles with instr_valid=1. halted=1 alongside the 0000 word, then instr_valid=0 and mem_addr stays 6. fetch_count=4.
- stall=1 for 3 cycles while instr=2222 is valid → instr, instr_pc=2 and mem_addr=4 hold, mem_en=0, fetch_count unchanged; after release the next output is 3333/4.
- redirect=1 with redirect_pc=16'h0040 while mem_rdata=16'h0000 → no halt; instr_valid=0 next cycle; mem_addr=0x0040; the next instruction is delivered with instr_pc=0x0040.
- redirect_pc=16'h0043 → mem_addr=0x0042; misalign=1 and it stays 1 until reset.
- PC wrap: redirect to 16'hFFFE with a non-halt word there → next instr_pc=FFFE, pc_plus2=0000, mem_addr=0000.
- In HALT with stall=1 → instr_valid held at 1. Then stall=0 → instr_valid=0. Then redirect to 0x0010 → ignored, halted=1. Then rst=0 for one edge → all outputs at reset values, and fetch resumes at 0x0000.
